sr_ff_p: RTL and testbench

- Parameterised bank of positive-edge-triggered SR flip-flops with synchronous active-low clear.
- Each bit is set by `s`, reset by `r`, and holds otherwise.
- A both-asserted conflict is resolved by a compile-time policy and flagged.
- Used as a small control/status latch primitive; the default WIDTH=1 is a single SR flip-flop.

---
 rtl/sr_ff_p.sv | 60 ++++++
 tb/tb_sr_ff_p.sv | 116 +++++++++++
 2 files changed

// File: rtl/sr_ff_p.sv
// rtl/sr_ff_p.sv - parameterised bank of SR flip-flops with sync active-low clear
module sr_ff_p #(
    parameter int               WIDTH         = 1,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
    parameter int               CONFLICT_MODE = 0
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clk,
    input  logic             clear,
    output logic [WIDTH-1:0] out_n,
    output logic [WIDTH-1:0] conflict
);

    // Out-of-range policy values fall back to reset-dominant.
    localparam logic MODE_SET    = (CONFLICT_MODE == 1);
    localparam logic MODE_HOLD   = (CONFLICT_MODE == 2);
    localparam logic MODE_TOGGLE = (CONFLICT_MODE == 3);
    localparam logic MODE_RESET  = !(MODE_SET || MODE_HOLD || MODE_TOGGLE);
    localparam logic [3:0] MODE_DEC = {MODE_TOGGLE, MODE_HOLD, MODE_SET, MODE_RESET};

    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] conflict_val;
    logic [WIDTH-1:0] out_next;

    assign both = s & r;

    always_comb begin
        conflict_val = '0;
        if (MODE_SET)
            conflict_val = {WIDTH{1'b1}};
        else if (MODE_HOLD)
            conflict_val = out;
        else if (MODE_TOGGLE)
            conflict_val = ~out;
    end

    // Each bit picks hold, set, reset, or its conflict action independently.
    always_comb begin
        out_next = (out | s) & ~r;
        out_next = (out_next & ~both) | (conflict_val & both);
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            out      <= RESET_VAL;
            conflict <= '0;
        end else begin
            out      <= out_next;
            conflict <= both;
        end
    end

    assign out_n = ~out;

    a_mode_onehot : assert property (@(posedge clk) $onehot(MODE_DEC));
    a_out_n       : assert property (@(posedge clk) out_n == ~out);

endmodule

// File: tb/tb_sr_ff_p.sv
// tb/tb_sr_ff_p.sv - directed self-checking bench for sr_ff_p
module tb_sr_ff_p;

    logic       clk = 1'b0;
    logic       clear;
    logic       s1, r1;
    logic [3:0] ws, wr;

    logic       o0, on0, c0;
    logic       o1, on1, c1;
    logic       o2, on2, c2;
    logic       o3, on3, c3;
    logic [3:0] wo, won, wc;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sr_ff_p #(.WIDTH(1), .CONFLICT_MODE(0)) u_m0 (
        .out(o0), .s(s1), .r(r1), .clk(clk), .clear(clear), .out_n(on0), .conflict(c0));
    sr_ff_p #(.WIDTH(1), .CONFLICT_MODE(1)) u_m1 (
        .out(o1), .s(s1), .r(r1), .clk(clk), .clear(clear), .out_n(on1), .conflict(c1));
    sr_ff_p #(.WIDTH(1), .CONFLICT_MODE(2)) u_m2 (
        .out(o2), .s(s1), .r(r1), .clk(clk), .clear(clear), .out_n(on2), .conflict(c2));
    sr_ff_p #(.WIDTH(1), .CONFLICT_MODE(3)) u_m3 (
        .out(o3), .s(s1), .r(r1), .clk(clk), .clear(clear), .out_n(on3), .conflict(c3));
    sr_ff_p #(.WIDTH(4), .RESET_VAL(4'b1010), .CONFLICT_MODE(0)) u_w (
        .out(wo), .s(ws), .r(wr), .clk(clk), .clear(clear), .out_n(won), .conflict(wc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b0; s1 = 1'b1; r1 = 1'b0; ws = 4'b0000; wr = 4'b0000;

        tick;
        check("rst1_out", 32'(o0), 32'd0);
        check("rst1_out_n", 32'(on0), 32'd1);
        check("rst1_conf", 32'(c0), 32'd0);
        check("rst1_wide", 32'(wo), 32'hA);
        check("rst1_wide_n", 32'(won), 32'h5);
        tick;
        check("rst2_out", 32'(o0), 32'd0);
        check("rst2_m3", 32'(o3), 32'd0);

        clear = 1'b1;
        s1 = 1'b1; r1 = 1'b0; tick;
        check("set", 32'(o0), 32'd1);
        check("set_out_n", 32'(on0), 32'd0);
        s1 = 1'b0; r1 = 1'b0; tick;
        check("hold1", 32'(o0), 32'd1);
        s1 = 1'b0; r1 = 1'b1; tick;
        check("reset", 32'(o0), 32'd0);
        s1 = 1'b0; r1 = 1'b0; tick;
        check("hold0", 32'(o0), 32'd0);

        // Pulse between edges must be invisible.
        s1 = 1'b1; #3; s1 = 1'b0; tick;
        check("glitch", 32'(o0), 32'd0);

        s1 = 1'b1; r1 = 1'b0; tick;
        check("preset_m0", 32'(o0), 32'd1);
        check("preset_m3", 32'(o3), 32'd1);

        s1 = 1'b1; r1 = 1'b1; tick;
        check("cf1_m0", 32'(o0), 32'd0);
        check("cf1_m1", 32'(o1), 32'd1);
        check("cf1_m2", 32'(o2), 32'd1);
        check("cf1_m3", 32'(o3), 32'd0);
        check("cf1_flags", 32'({c0, c1, c2, c3}), 32'hF);
        tick;
        check("cf2_m0", 32'(o0), 32'd0);
        check("cf2_m1", 32'(o1), 32'd1);
        check("cf2_m2", 32'(o2), 32'd1);
        check("cf2_m3", 32'(o3), 32'd1);
        check("cf2_flags", 32'({c0, c1, c2, c3}), 32'hF);

        s1 = 1'b0; r1 = 1'b0; tick;
        check("cf_end_out", 32'(o0), 32'd0);
        check("cf_end_conf", 32'(c0), 32'd0);

        s1 = 1'b1; r1 = 1'b0; tick;
        check("mid_pre", 32'(o0), 32'd1);
        clear = 1'b0; s1 = 1'b1; r1 = 1'b1; ws = 4'b0101; tick;
        check("mid_clr", 32'(o0), 32'd0);
        check("mid_clr_conf", 32'(c0), 32'd0);
        check("mid_clr_wide", 32'(wo), 32'hA);
        clear = 1'b1; s1 = 1'b1; r1 = 1'b0; ws = 4'b0000; tick;
        check("mid_rel", 32'(o0), 32'd1);

        ws = 4'b0001; wr = 4'b1000; tick;
        check("wide_sr", 32'(wo), 32'h3);
        check("wide_sr_conf", 32'(wc), 32'h0);
        ws = 4'b0100; wr = 4'b0100; tick;
        check("wide_cf_out", 32'(wo), 32'h3);
        check("wide_cf_flag", 32'(wc), 32'h4);
        ws = 4'b0000; wr = 4'b0000; tick;
        check("wide_cf_clr", 32'(wc), 32'h0);
        check("wide_hold", 32'(wo), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
